// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master gpiomem arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    CORE0 = 1'b0,
    CORE1 = 1'b1
  } master_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam logic [7:0] OOR_READ_DATA = 8'h00;

endpackage

// File: rtl/bus_arbiter_if.sv
// Core request/response lines plus the gpiomem port, bundled for the arbiter.
interface bus_arbiter_if #(
  parameter int DATA_W  = 8,
  parameter int CORE_AW = 10,
  parameter int RAM_AW  = 9
);
  logic                core0_request;
  logic                core0_rw;
  logic [CORE_AW-1:0]  core0_address;
  logic [DATA_W-1:0]   core0_wdata;
  logic [DATA_W-1:0]   core0_rdata;
  logic                core0_grant;

  logic                core1_request;
  logic                core1_rw;
  logic [CORE_AW-1:0]  core1_address;
  logic [DATA_W-1:0]   core1_wdata;
  logic [DATA_W-1:0]   core1_rdata;
  logic                core1_grant;

  logic [RAM_AW-1:0]   ram_address;
  logic [DATA_W-1:0]   ram_wdata;
  logic                ram_rw;
  logic [DATA_W-1:0]   ram_rdata;
  logic                bus_error;

  // Arbiter side: serves the cores and drives gpiomem.
  modport slave (
    input  core0_request, core0_rw, core0_address, core0_wdata,
    input  core1_request, core1_rw, core1_address, core1_wdata,
    input  ram_rdata,
    output core0_rdata, core0_grant, core1_rdata, core1_grant,
    output ram_address, ram_wdata, ram_rw, bus_error
  );

  // Requester/memory side.
  modport master (
    output core0_request, core0_rw, core0_address, core0_wdata,
    output core1_request, core1_rw, core1_address, core1_wdata,
    output ram_rdata,
    input  core0_rdata, core0_grant, core1_rdata, core1_grant,
    input  ram_address, ram_wdata, ram_rw, bus_error
  );
endinterface

// File: rtl/bus_arbiter_rr_select.sv
// Two-way round-robin pick: on a tie the core that was not served last wins.
module rr_select
  import bus_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  master_t last_served,
  output logic    valid,
  output master_t pick
);

  // Combinational winner selection.
  always_comb begin
    valid = req0 | req1;
    pick  = CORE0;
    if (req0 && req1) begin
      pick = (last_served == CORE0) ? CORE1 : CORE0;
    end else if (req1) begin
      pick = CORE1;
    end else begin
      pick = CORE0;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin sequencer sharing one gpiomem port between core0 and core1;
// performs one transfer per grant and flags out-of-range accesses.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CORE_AW    = 10,
  parameter int RAM_AW     = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  bus_arbiter_if.slave    bus
);

  localparam int CNT_W = 2;

  state_t              state_r, state_s;
  master_t             winner_r, winner_s;
  master_t             last_served_r, last_served_s;
  master_t             pick_s;
  logic                pick_valid_s;
  logic                rw_r, rw_s;
  logic                oor_r, oor_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [RAM_AW-1:0]   ram_address_r, ram_address_s;
  logic [DATA_W-1:0]   ram_wdata_r, ram_wdata_s;
  logic                ram_rw_r, ram_rw_s;
  logic [DATA_W-1:0]   core0_rdata_r, core0_rdata_s;
  logic [DATA_W-1:0]   core1_rdata_r, core1_rdata_s;
  logic                core0_grant_r, core0_grant_s;
  logic                core1_grant_r, core1_grant_s;
  logic                bus_error_r, bus_error_s;
  logic [CORE_AW-1:0]  sel_address_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                sel_rw_s;
  logic [DATA_W-1:0]   done_rdata_s;

  rr_select u_rr_select (
    .req0        (bus.core0_request),
    .req1        (bus.core1_request),
    .last_served (last_served_r),
    .valid       (pick_valid_s),
    .pick        (pick_s)
  );

  // Route the request fields of the round-robin winner.
  always_comb begin
    if (pick_s == CORE1) begin
      sel_address_s = bus.core1_address;
      sel_wdata_s   = bus.core1_wdata;
      sel_rw_s      = bus.core1_rw;
    end else begin
      sel_address_s = bus.core0_address;
      sel_wdata_s   = bus.core0_wdata;
      sel_rw_s      = bus.core0_rw;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so they can be registered.
  always_comb begin
    state_s       = state_r;
    winner_s      = winner_r;
    last_served_s = last_served_r;
    rw_s          = rw_r;
    oor_s         = oor_r;
    cnt_s         = cnt_r;
    ram_address_s = ram_address_r;
    ram_wdata_s   = ram_wdata_r;
    ram_rw_s      = 1'b0;
    core0_rdata_s = core0_rdata_r;
    core1_rdata_s = core1_rdata_r;
    core0_grant_s = 1'b0;
    core1_grant_s = 1'b0;
    bus_error_s   = 1'b0;
    done_rdata_s  = bus.ram_rdata;

    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          winner_s      = pick_s;
          rw_s          = sel_rw_s;
          oor_s         = sel_address_s[CORE_AW-1];
          ram_address_s = sel_address_s[RAM_AW-1:0];
          ram_wdata_s   = sel_wdata_s;
          ram_rw_s      = (sel_rw_s == RW_WRITE) && !sel_address_s[CORE_AW-1];
          state_s       = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end

      ACCESS: begin
        if (oor_r || (rw_r == RW_WRITE)) begin
          // Out-of-range accesses skip WAIT and report the error with the grant.
          state_s       = DONE;
          bus_error_s   = oor_r;
          core0_grant_s = (winner_r == CORE0);
          core1_grant_s = (winner_r == CORE1);
          done_rdata_s  = DATA_W'(OOR_READ_DATA);
          if (oor_r && (rw_r == RW_READ) && (winner_r == CORE0)) begin
            core0_rdata_s = done_rdata_s;
          end else if (oor_r && (rw_r == RW_READ)) begin
            core1_rdata_s = done_rdata_s;
          end else begin
            core0_rdata_s = core0_rdata_r;
          end
        end else begin
          state_s = WAIT;
          cnt_s   = CNT_W'(RD_LATENCY - 1);
        end
      end

      WAIT: begin
        if (cnt_r == '0) begin
          state_s       = DONE;
          core0_grant_s = (winner_r == CORE0);
          core1_grant_s = (winner_r == CORE1);
          if (winner_r == CORE0) begin
            core0_rdata_s = done_rdata_s;
          end else begin
            core1_rdata_s = done_rdata_s;
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end

      DONE: begin
        last_served_s = winner_r;
        state_s       = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Transfer context and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      winner_r      <= CORE0;
      last_served_r <= CORE1;
      rw_r          <= RW_READ;
      oor_r         <= 1'b0;
      cnt_r         <= '0;
      ram_address_r <= '0;
      ram_wdata_r   <= '0;
      ram_rw_r      <= 1'b0;
      core0_rdata_r <= '0;
      core1_rdata_r <= '0;
      core0_grant_r <= 1'b0;
      core1_grant_r <= 1'b0;
      bus_error_r   <= 1'b0;
    end else begin
      winner_r      <= winner_s;
      last_served_r <= last_served_s;
      rw_r          <= rw_s;
      oor_r         <= oor_s;
      cnt_r         <= cnt_s;
      ram_address_r <= ram_address_s;
      ram_wdata_r   <= ram_wdata_s;
      ram_rw_r      <= ram_rw_s;
      core0_rdata_r <= core0_rdata_s;
      core1_rdata_r <= core1_rdata_s;
      core0_grant_r <= core0_grant_s;
      core1_grant_r <= core1_grant_s;
      bus_error_r   <= bus_error_s;
    end
  end

  assign bus.ram_address = ram_address_r;
  assign bus.ram_wdata   = ram_wdata_r;
  assign bus.ram_rw      = ram_rw_r;
  assign bus.core0_rdata = core0_rdata_r;
  assign bus.core1_rdata = core1_rdata_r;
  assign bus.core0_grant = core0_grant_r;
  assign bus.core1_grant = core1_grant_r;
  assign bus.bus_error   = bus_error_r;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter and sequencer that shares the single gpiomem port between core0 and core1.
- Each core raises a request with address, rw and write data. The arbiter selects one core by round-robin and performs one memory transfer on the gpiomem lines.
- On completion it returns read data and pulses that core's grant for one cycle.
- Sits between the two cores and gpiomem in top, as the sequencing brain of the system bus.

Parameters:
- DATA_W, 8, data width of core and RAM data paths
- CORE_AW, 10, core address width; MSB selects out-of-range space
- RAM_AW, 9, gpiomem address width (CORE_AW-1)
- RD_LATENCY, 1, cycles from address presented to gpiomem data_out valid (1..4)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- core0_request  input  1  core0 wants a transfer; held until grant
- core0_rw  input  1  1=write, 0=read
- core0_address  input  CORE_AW  core0 transfer address
- core0_wdata  input  DATA_W  core0 write data
- core0_rdata  output  DATA_W  read data returned to core0
- core0_grant  output  1  one-cycle completion pulse to core0
- core1_request / core1_rw / core1_address / core1_wdata / core1_rdata / core1_grant  same as core0
- ram_address  output  RAM_AW  to gpiomem address
- ram_wdata  output  DATA_W  to gpiomem data_in
- ram_rw  output  1  gpiomem write strobe, 1 = write this cycle
- ram_rdata  input  DATA_W  from gpiomem data_out
- bus_error  output  1  one-cycle pulse on an out-of-range access

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset). All state updates on the rising edge of clk; reset is sampled only on that edge.
- Reset values: all outputs 0, state IDLE, last_served = core1 (so core0 wins the first tie).
- States:
  - IDLE: sample requests. None: stay. One: select it. Both: select the core != last_served. Latch address, rw and wdata of the winner, then go to ACCESS.
  - ACCESS: one cycle; drive latched ram_address = addr[RAM_AW-1:0] and ram_wdata.
    - Write: ram_rw=1 this cycle only, then DONE.
    - Read: ram_rw=0, then WAIT.
  - WAIT: hold ram_address. Counter runs RD_LATENCY-1 cycles, so ram_rdata is valid in the last WAIT cycle. Sample ram_rdata into the winner's rdata register at the end of that cycle, then DONE.
  - DONE: winner's grant=1 for exactly this cycle; last_served = winner; go to IDLE.
- Latency, with request first seen in IDLE at cycle N:
  - Write: ram_rw high in N+1, grant in N+2.
  - Read: grant in N+2+RD_LATENCY (default N+3). coreX_rdata is valid from that cycle.
- coreX_rdata holds its value until the next completed read by the same core. Writes do not change it.
- ram_rw is never high outside ACCESS. ram_address and ram_wdata hold their last values in IDLE.
- Out-of-range access (address[CORE_AW-1]=1):
  - No RAM access: ram_rw stays 0 and WAIT is skipped.
  - Read returns 8'h00.
  - Goes straight from ACCESS to DONE; grant and bus_error pulse together.
- Requests are sampled only in IDLE.
  - A request dropped mid-transfer does not abort it; the transfer completes and grant still pulses.
  - A request still high in the IDLE cycle after DONE is a new transfer. Round-robin then favours the other core if it is waiting.
- A request while the other core is being served waits. Worst-case wait is one full transfer of the other core.
- Reset low in any state: next cycle IDLE with all outputs 0, including rdata registers. A write in progress is abandoned, and ram_rw is 0 from the cycle after reset is sampled.

Decomposition:
- Package bus_pkg holds:
  - state_t enum (IDLE, ACCESS, WAIT, DONE)
  - master_t enum (CORE0, CORE1)
  - RW_WRITE/RW_READ constants
  - OOR_READ_DATA = 8'h00
- One natural sub-module: rr_select. Combinational two-way round-robin pick from the request pair and last_served.

Test Plan:
- Reset then core0 write address 0x012, data 0xA5, RAM_LAT 1 -> ram_rw=1 with ram_address 0x012 and ram_wdata 0xA5 at N+1; core0_grant at N+2; core1_grant stays 0.
- core1 read of 0x012 with gpiomem model returning 0xA5 -> core1_grant at N+3; core1_rdata=0xA5; core0_rdata unchanged.
- Both cores request in the same cycle from reset -> core0 served first, then core1. Repeat both held -> grants alternate 0,1,0,1.
- core0 read of address 0x200 -> no ram_rw; core0_grant and bus_error both pulse at N+2; core0_rdata=0x00.
- Reset asserted in the ACCESS cycle of a core1 write -> ram_rw=0 next cycle; no grant; all outputs 0; next request is served normally.
- RD_LATENCY=3, core0 read with the model delaying data 3 cycles -> core0_grant at N+5 with correct data; ram_address stable from N+1 to N+4.
